// File: rtl/ngv_lcd_pkg.sv
// ngv_lcd_pkg: shared definitions for the 8080-style LCD bus master.
//   - lcd_state_t : FSM state encoding (read states only with LCD_READ_EN)
//   - DEF_*       : default timing constants, in pclk cycles
//   - DATA_W      : panel data bus width
//   - TIMER_W     : width of the dwell down-counter
//   - dwell()     : converts a dwell length in cycles to the timer load value
// Optional feature macro: LCD_READ_EN (adds the panel read states).
package ngv_lcd_pkg;

  localparam int DATA_W  = 16;
  localparam int TIMER_W = 16;

  localparam int DEF_WR_LOW_CYC   = 2;
  localparam int DEF_WR_HIGH_CYC  = 2;
  localparam int DEF_RST_CYC      = 1000;
  localparam int DEF_RST_WAIT_CYC = 1000;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    RST_WAIT   = 3'd1,
    IDLE       = 3'd2,
    SETUP      = 3'd3,
    WR_LOW     = 3'd4,
    WR_HIGH    = 3'd5
`ifdef LCD_READ_EN
    ,
    RD_LOW     = 3'd6,
    RD_HIGH    = 3'd7
`endif
  } lcd_state_t;

  // The timer is loaded on the edge that enters a state and the state is left
  // on the edge where the count is zero, so an N-cycle dwell loads N-1.
  function automatic logic [TIMER_W-1:0] dwell(input int unsigned cyc);
    return TIMER_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_master_if.sv
// lcd_bus_master_if: request handshake and panel strobes of lcd_bus_master.
//   master modport : the bus master block (drives in_ready, busy, lcd_*)
//   slave modport  : the request source / panel side
//   Request side : in_valid, in_ready, in_rs, in_data, bl_en, busy
//   Panel side   : lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_blk,
//                  lcd_data, lcd_doe
//   With LCD_READ_EN: in_rd, lcd_din, rd_valid, rd_data
interface lcd_bus_master_if;
  import ngv_lcd_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_rs;
  logic [DATA_W-1:0] in_data;
  logic              bl_en;
  logic              busy;

  logic              lcd_cs;
  logic              lcd_rs;
  logic              lcd_wr;
  logic              lcd_rd;
  logic              lcd_rst;
  logic              lcd_blk;
  logic [DATA_W-1:0] lcd_data;
  logic              lcd_doe;

`ifdef LCD_READ_EN
  logic              in_rd;
  logic [DATA_W-1:0] lcd_din;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
`endif

  modport master (
    input  in_valid, in_rs, in_data, bl_en,
`ifdef LCD_READ_EN
    input  in_rd, lcd_din,
    output rd_valid, rd_data,
`endif
    output in_ready, busy,
    output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_blk, lcd_data, lcd_doe
  );

  modport slave (
    output in_valid, in_rs, in_data, bl_en,
`ifdef LCD_READ_EN
    output in_rd, lcd_din,
    input  rd_valid, rd_data,
`endif
    input  in_ready, busy,
    input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst, lcd_blk, lcd_data, lcd_doe
  );

endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable 16-bit down-counter used for every FSM dwell.
//   pclk     : clock
//   prst     : asynchronous active-high reset (count cleared)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   done     : count has reached zero
module lcd_timer
  import ngv_lcd_pkg::*;
(
  input  logic               pclk,
  input  logic               prst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/lcd_bus_master.sv
// lcd_bus_master: 8080-style parallel LCD write master with power-up reset
// sequencing of the panel.
//   pclk : clock, prst : asynchronous active-high reset
//   bus  : lcd_bus_master_if.master (request handshake + panel strobes)
// Parameters: WR_LOW_CYC, WR_HIGH_CYC (1..15), RST_CYC, RST_WAIT_CYC.
// Optional feature macro: LCD_READ_EN (panel read path: in_rd, lcd_din,
// rd_valid, rd_data; RD_LOW/RD_HIGH states). Without it lcd_rd is tied high.
module lcd_bus_master
  import ngv_lcd_pkg::*;
#(
  parameter int WR_LOW_CYC   = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input logic              pclk,
  input logic              prst,
  lcd_bus_master_if.master bus
);

  lcd_state_t         state_reg, state_next;
  logic               start_reg;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;
  logic               capture;
  logic               xfer_next;
  logic               doe_next;

  logic               cs_reg, rs_reg, wr_reg, rst_reg, blk_reg, doe_reg;
  logic [DATA_W-1:0]  data_reg;

`ifdef LCD_READ_EN
  logic               rd_op_reg, rd_op_next;
  logic               rd_reg;
  logic               rd_valid_reg;
  logic [DATA_W-1:0]  rd_data_reg;
`endif

  lcd_timer u_timer (
    .pclk     (pclk),
    .prst     (prst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state and timer control. Every transition loads the dwell of the
  // state being entered. RST_ASSERT is entered by reset rather than by an
  // edge, so its dwell is loaded on the first clock after release.
  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    capture    = 1'b0;
    case (state_reg)
      RST_ASSERT: begin
        if (start_reg) begin
          tmr_load = 1'b1;
          tmr_val  = dwell(RST_CYC);
        end else if (tmr_done) begin
          state_next = RST_WAIT;
          tmr_load   = 1'b1;
          tmr_val    = dwell(RST_WAIT_CYC);
        end
      end
      RST_WAIT: begin
        if (tmr_done) state_next = IDLE;
      end
      IDLE: begin
        if (bus.in_valid) begin
          state_next = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = dwell(1);
          capture    = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_done) begin
`ifdef LCD_READ_EN
          state_next = rd_op_reg ? RD_LOW : WR_LOW;
`else
          state_next = WR_LOW;
`endif
          tmr_load = 1'b1;
          tmr_val  = dwell(WR_LOW_CYC);
        end
      end
      WR_LOW: begin
        if (tmr_done) begin
          state_next = WR_HIGH;
          tmr_load   = 1'b1;
          tmr_val    = dwell(WR_HIGH_CYC);
        end
      end
      WR_HIGH: begin
        if (tmr_done) state_next = IDLE;
      end
`ifdef LCD_READ_EN
      RD_LOW: begin
        if (tmr_done) begin
          state_next = RD_HIGH;
          tmr_load   = 1'b1;
          tmr_val    = dwell(WR_HIGH_CYC);
        end
      end
      RD_HIGH: begin
        if (tmr_done) state_next = IDLE;
      end
`endif
      default: state_next = RST_ASSERT;
    endcase
  end

  // Strobes are registered from the next state so they change exactly on the
  // state edge and never glitch.
  always_comb begin
    xfer_next = (state_next == SETUP) || (state_next == WR_LOW) ||
                (state_next == WR_HIGH);
`ifdef LCD_READ_EN
    xfer_next  = xfer_next || (state_next == RD_LOW) || (state_next == RD_HIGH);
    rd_op_next = capture ? bus.in_rd : rd_op_reg;
    doe_next   = xfer_next && !rd_op_next;
`else
    doe_next   = xfer_next;
`endif
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_reg <= RST_ASSERT;
      start_reg <= 1'b1;
      cs_reg    <= 1'b1;
      rs_reg    <= 1'b0;
      wr_reg    <= 1'b1;
      rst_reg   <= 1'b0;
      blk_reg   <= 1'b0;
      doe_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      start_reg <= 1'b0;
      cs_reg    <= !xfer_next;
      wr_reg    <= (state_next != WR_LOW);
      rst_reg   <= (state_next != RST_ASSERT);
      blk_reg   <= bus.bl_en;
      doe_reg   <= doe_next;
      // Word is latched only at the handshake; later in_data changes are
      // invisible and the bus keeps the last word while idle.
      if (capture) begin
        rs_reg   <= bus.in_rs;
        data_reg <= bus.in_data;
      end
    end
  end

`ifdef LCD_READ_EN
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rd_op_reg    <= 1'b0;
      rd_reg       <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_op_reg    <= rd_op_next;
      rd_reg       <= (state_next != RD_LOW);
      rd_valid_reg <= (state_reg == RD_HIGH) && (state_next == IDLE);
      // Panel data is taken on the edge that ends the last RD_LOW cycle.
      if ((state_reg == RD_LOW) && (state_next == RD_HIGH)) begin
        rd_data_reg <= bus.lcd_din;
      end
    end
  end

  assign bus.lcd_rd   = rd_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = rd_data_reg;
`else
  assign bus.lcd_rd   = 1'b1;
`endif

  assign bus.in_ready = (state_reg == IDLE);
  assign bus.busy     = (state_reg != IDLE);
  assign bus.lcd_cs   = cs_reg;
  assign bus.lcd_rs   = rs_reg;
  assign bus.lcd_wr   = wr_reg;
  assign bus.lcd_rst  = rst_reg;
  assign bus.lcd_blk  = blk_reg;
  assign bus.lcd_doe  = doe_reg;
  assign bus.lcd_data = data_reg;

endmodule

// File: tb/tb_lcd_bus_master.sv
// tb_lcd_bus_master: directed self-checking bench for lcd_bus_master.
// Expected panel words are pushed to a scoreboard queue at each handshake and
// popped by a monitor on every completed lcd_wr pulse. Outputs are sampled on
// the falling edge. Rising edges after a prst release are numbered from 1:
// lcd_rst is expected high from edge 1001 and in_ready from edge 2001.
module tb_lcd_bus_master;

  localparam int LOW_CYC = 2;
  localparam int PERIOD  = 6;

  logic pclk;
  logic prst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [16:0] exp_q[$];
  int          rise_cyc[$];
  int          rise_count = 0;
  int          wr_low_run = 0;
  logic        wr_prev = 1'b1;

  lcd_bus_master_if bus_if ();

  lcd_bus_master #(
    .WR_LOW_CYC   (2),
    .WR_HIGH_CYC  (2),
    .RST_CYC      (1000),
    .RST_WAIT_CYC (1000)
  ) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus_if.master)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Monitor: every rising lcd_wr outside reset completes one panel write.
  always @(negedge pclk) begin
    logic        avail;
    logic [16:0] e;
    if (prst) begin
      wr_low_run = 0;
    end else if (bus_if.lcd_wr === 1'b0) begin
      wr_low_run++;
    end else if (wr_prev === 1'b0) begin
      rise_count++;
      rise_cyc.push_back(cyc);
      chk("wr_low_len", wr_low_run, LOW_CYC);
      chk("wr_cs_low", bus_if.lcd_cs, 1'b0);
      avail = (exp_q.size() > 0);
      chk("sb_avail", avail, 1'b1);
      if (avail) begin
        e = exp_q.pop_front();
        chk("sb_word", {bus_if.lcd_rs, bus_if.lcd_data}, e);
      end
      wr_low_run = 0;
    end
    wr_prev = bus_if.lcd_wr;
  end

  // Called right after prst is released on a falling edge.
  task automatic reset_seq(input string tag);
    int k = 0;
    int rst_rise = 0;
    int rdy_rise = 0;
    while (k < 3000 && rdy_rise == 0) begin
      @(negedge pclk);
      k++;
      if (rst_rise == 0 && bus_if.lcd_rst === 1'b1) rst_rise = k;
      if (bus_if.in_ready === 1'b1) rdy_rise = k;
      if (k == 6) chk({tag, "_blk_on"}, bus_if.lcd_blk, 1'b1);
      if (k == 7) chk({tag, "_blk_off"}, bus_if.lcd_blk, 1'b0);
      if (k == 5) bus_if.bl_en = 1'b1;
      if (k == 6) bus_if.bl_en = 1'b0;
    end
    chk({tag, "_lcd_rst_rise"}, rst_rise, 1001);
    chk({tag, "_in_ready_rise"}, rdy_rise, 2001);
    chk({tag, "_busy"}, bus_if.busy, 1'b0);
  endtask

  // Called on a falling edge; one full write with per-cycle strobe checks.
  task automatic do_write(input string tag, input logic rs, input logic [15:0] data,
                          input bit bl_toggle);
    logic [5:0] cs_v, wr_v, rdy_v;
    int to = 0;
    bus_if.in_rs    = rs;
    bus_if.in_data  = data;
    bus_if.in_valid = 1'b1;
    while (bus_if.in_ready !== 1'b1 && to < 50) begin
      @(negedge pclk);
      to++;
    end
    chk({tag, "_ready"}, bus_if.in_ready, 1'b1);
    exp_q.push_back({rs, data});
    for (int m = 1; m <= 6; m++) begin
      @(negedge pclk);
      cs_v[m-1]  = bus_if.lcd_cs;
      wr_v[m-1]  = bus_if.lcd_wr;
      rdy_v[m-1] = bus_if.in_ready;
      if (m == 1) begin
        chk({tag, "_setup_data"}, bus_if.lcd_data, data);
        chk({tag, "_setup_rs_doe"}, {bus_if.lcd_rs, bus_if.lcd_doe}, {rs, 1'b1});
        bus_if.in_data = ~data;   // in_valid stays high: must be ignored
      end
      if (bl_toggle) begin
        if (m == 2) chk({tag, "_blk_pre"}, bus_if.lcd_blk, 1'b0);
        if (m == 3) chk({tag, "_blk_on"}, bus_if.lcd_blk, 1'b1);
        if (m == 4) chk({tag, "_blk_off"}, bus_if.lcd_blk, 1'b0);
        if (m == 2) bus_if.bl_en = 1'b1;
        if (m == 3) bus_if.bl_en = 1'b0;
      end
      if (m == 5) bus_if.in_valid = 1'b0;
    end
    chk({tag, "_cs_pattern"}, cs_v, 6'b100000);
    chk({tag, "_wr_pattern"}, wr_v, 6'b111001);
    chk({tag, "_ready_pattern"}, rdy_v, 6'b100000);
    chk({tag, "_idle_hold"}, {bus_if.lcd_doe, bus_if.busy, bus_if.lcd_data}, {2'b00, data});
    @(negedge pclk);
    chk({tag, "_no_recapture"}, {bus_if.in_ready, bus_if.lcd_cs}, 2'b11);
  endtask

  initial begin
    logic [15:0] words[4];
    int          hs[4];
    int          r0;
    int          to;
    int          n;

    words = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    bus_if.in_valid = 1'b0;
    bus_if.in_rs    = 1'b0;
    bus_if.in_data  = '0;
    bus_if.bl_en    = 1'b0;
`ifdef LCD_READ_EN
    bus_if.in_rd    = 1'b0;
    bus_if.lcd_din  = '0;
`endif
    prst = 1'b0;
    #1 prst = 1'b1;
    #1;
    chk("reset_strobes",
        {bus_if.lcd_cs, bus_if.lcd_wr, bus_if.lcd_rd, bus_if.lcd_rs, bus_if.lcd_rst,
         bus_if.lcd_blk, bus_if.lcd_doe, bus_if.in_ready, bus_if.busy},
        9'b111000001);
    chk("reset_data", bus_if.lcd_data, 16'h0000);
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    reset_seq("rst1");

    // Single command write.
    do_write("wr_cmd", 1'b0, 16'h002C, 1'b0);

    // Back-to-back data words with in_valid held high.
    r0 = rise_count;
    bus_if.in_rs    = 1'b1;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.in_data = words[i];
      to = 0;
      while (bus_if.in_ready !== 1'b1 && to < 50) begin
        @(negedge pclk);
        to++;
      end
      hs[i] = cyc + 1;
      exp_q.push_back({1'b1, words[i]});
      @(negedge pclk);
    end
    bus_if.in_valid = 1'b0;
    to = 0;
    while (exp_q.size() != 0 && to < 100) begin
      @(negedge pclk);
      to++;
    end
    for (int i = 1; i < 4; i++) chk("b2b_hs_period", hs[i] - hs[i-1], PERIOD);
    chk("b2b_pulses", rise_count - r0, 4);
    n = rise_cyc.size();
    if (n >= 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_wr_period", rise_cyc[n-4+i] - rise_cyc[n-5+i], PERIOD);
    end

    // Backlight toggled mid-write.
    @(negedge pclk);
    do_write("wr_blk", 1'b1, 16'h1234, 1'b1);

    // Reset pulsed during WR_LOW aborts the write.
    r0 = rise_count;
    bus_if.in_rs    = 1'b0;
    bus_if.in_data  = 16'hA5A5;
    bus_if.in_valid = 1'b1;
    to = 0;
    while (bus_if.in_ready !== 1'b1 && to < 50) begin
      @(negedge pclk);
      to++;
    end
    exp_q.push_back({1'b0, 16'hA5A5});
    @(negedge pclk);
    bus_if.in_valid = 1'b0;
    @(negedge pclk);
    chk("abort_in_wr_low", bus_if.lcd_wr, 1'b0);
    #1 prst = 1'b1;
    #1;
    chk("abort_strobes",
        {bus_if.lcd_wr, bus_if.lcd_cs, bus_if.lcd_rst, bus_if.busy, bus_if.in_ready,
         bus_if.lcd_doe},
        6'b110100);
    chk("abort_data", bus_if.lcd_data, 16'h0000);
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    chk("abort_no_wr_edge", rise_count - r0, 0);
    chk("abort_sb_depth", exp_q.size(), 1);
    exp_q.delete();
    reset_seq("rst2");
    do_write("wr_after_abort", 1'b1, 16'h5A5A, 1'b0);

`ifdef LCD_READ_EN
    begin
      logic [6:0] rd_v, doe_v, rv_v;
      bus_if.lcd_din  = 16'h9341;
      bus_if.in_rd    = 1'b1;
      bus_if.in_rs    = 1'b1;
      bus_if.in_valid = 1'b1;
      to = 0;
      while (bus_if.in_ready !== 1'b1 && to < 50) begin
        @(negedge pclk);
        to++;
      end
      for (int m = 1; m <= 7; m++) begin
        @(negedge pclk);
        rd_v[m-1]  = bus_if.lcd_rd;
        doe_v[m-1] = bus_if.lcd_doe;
        rv_v[m-1]  = bus_if.rd_valid;
        if (m == 1) begin
          bus_if.in_valid = 1'b0;
          bus_if.in_rd    = 1'b0;
        end
        if (m == 6) chk("rd_data", bus_if.rd_data, 16'h9341);
      end
      chk("rd_pattern", rd_v, 7'b1111001);
      chk("rd_doe", doe_v, 7'b0000000);
      chk("rd_valid_pulse", rv_v, 7'b0100000);
    end
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
